dep_rule_conf_writer: RTL
=========================

// Module: dep_rule_conf_writer
// PURPOSE
//  Transmit side of the deparser rule-config bus: accepts one complete rule record over valid/ready.
//  Serialises the record into the 32b wren/addr/wdata write sequence consumed by the deparser rule-config
//  receiver, one write per cycle, ending with the rule-commit write. Sits between the control-plane agent
//  and the deparser rule-config receiver.
// PARAMETERS
//  TYPE_NUM          4  type fields per rule (<=16)
//  TYPE_WIDTH        16 type data/mask width (<=16)
//  TYPE_OFFSET_WIDTH 8  type offset width (<=32)
//  KEY_FILED_NUM     8  key fields per rule (<=64)
//  KEY_OFFSET_WIDTH  5  key/replace offset width (<=8)
//  HEAD_SHIFT_WIDTH  8  head shift width; META_SHIFT_WIDTH 8 meta shift width
//  RULE_ID_WIDTH     6  rule id width (<=6)
// PORTS
//  i_clk           in  1  clock
//  i_rst_n         in  1  async active-low reset
//  i_req_valid     in  1  rule record valid
//  o_req_ready     out 1  writer idle, record accepted when valid&&ready
//  i_req_ruleId    in  RULE_ID_WIDTH  target rule id
//  i_req_ruleValid in  1  rule valid bit, sent in commit write
//  i_req_typeData  in  TYPE_NUM*TYPE_WIDTH  packed, [t] = type t
//  i_req_typeMask  in  TYPE_NUM*TYPE_WIDTH
//  i_req_typeOffset in TYPE_NUM*TYPE_OFFSET_WIDTH
//  i_req_keyOffset in  KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)  top bit of each field = key valid
//  i_req_keyReplaceOffset in KEY_FILED_NUM*KEY_OFFSET_WIDTH
//  i_req_headShift in  HEAD_SHIFT_WIDTH; i_req_metaShift in META_SHIFT_WIDTH
//  o_rule_wren     out 1  config write strobe
//  o_rule_addr     out 32 config address
//  o_rule_wdata    out 32 config data
//  o_done          out 1  one-cycle pulse: sequence complete
// BEHAVIOUR
//  Reset: o_rule_wren=0, o_rule_addr=0, o_rule_wdata=0, o_done=0, o_req_ready=1, FSM=IDLE, all snapshots 0.
//  o_req_ready is 1 only in IDLE; a handshake snapshots all i_req_* into registers; inputs are don't-care afterwards.
//  FSM IDLE->TYPE->TOFF->KEY->HEAD->META->COMMIT->IDLE; index counter idx cleared on every phase entry.
//  Each write cycle is registered: wren=1, addr/wdata as below. Unused addr/wdata bits are 0:
//   TYPE  idx 0..TYPE_NUM-1:      addr[10:8]=1, addr[3:0]=idx, wdata[31:16]=typeData[idx], wdata[15:0]=typeMask[idx].
//   TOFF  idx 0..TYPE_NUM-1:      addr[10:8]=2, addr[3:0]=idx, wdata[TYPE_OFFSET_WIDTH-1:0]=typeOffset[idx].
//   KEY   idx 0..KEY_FILED_NUM-1: addr[10:8]=3, addr[5:0]=idx, wdata[16]=key valid bit,
//         wdata[8+:KEY_OFFSET_WIDTH]=replaceOffset, wdata[0+:KEY_OFFSET_WIDTH]=keyOffset.
//   HEAD: addr[10:8]=4, wdata=headShift.  META: addr[10:8]=5, wdata=metaShift.
//   COMMIT: addr[10:8]=0, addr[5:0]=ruleId, wdata[0]=ruleValid. Always the last write.
//  Narrow fields are zero-extended.
//  N = 2*TYPE_NUM+KEY_FILED_NUM+3 writes (19 at defaults). Handshake at cycle 0 -> writes in cycles 1..N,
//   o_done=1 and o_req_ready=1 in cycle N+1.
//  A new handshake is allowed in cycle N+1; its first write follows in cycle N+2. Max throughput is 1 rule per N+1 cycles.
//  i_req_valid while busy: ignored, no effect on the sequence in flight.
//  Reset mid-sequence: all outputs are forced to their reset values asynchronously and the FSM returns to IDLE.
//   The COMMIT write is never issued for the aborted rule. Partial type/key writes may already be at the receiver;
//   the commit-last ordering guarantees they are not activated.
//  Elaboration: $error if any width bound above is violated.
// CONFIGURATION
//  DEP_RULE_CONF_WRITE_GAP_EN: when defined, one idle cycle (wren=0, addr/wdata hold) is inserted after every write.
//   This is for receivers behind a slow/CDC path. Write k lands in cycle 2k-1, so writes occupy cycles 1..2N-1,
//   and o_done/o_req_ready occur in cycle 2N.
//   When undefined, writes are back-to-back as above.
// TESTING
//  1) ruleId=5, ruleValid=1, typeData[t]=16'h0800+t, mask=16'hFFFF, typeOffset[t]=12+t, key k: valid=1,
//     off=k, repl=k+8, head=14, meta=2 -> exactly 19 writes in order;
//     write 1 = addr 0x100 / data 0x0800FFFF; key 3 = addr 0x303 / data 0x00010B03;
//     last = addr 0x005 / data 0x1; o_done in cycle 20.
//  2) i_req_valid held high with two records -> second accepted in cycle 20, its first write in cycle 21,
//     no duplicated or dropped write.
//  3) Pulse i_req_valid with a different record in cycle 7 -> o_req_ready=0, sequence unchanged, record not taken.
//  4) Assert i_rst_n=0 during KEY idx 4 -> wren drops immediately, no addr[10:8]=0 write ever seen,
//     o_req_ready=1 after release.
//  5) Key valid=0 with max fields typeData=16'hFFFF, repl=5'h1F -> wdata bit16=0, bits[12:8]=5'h1F, no bleed into other bits.
//  6) DEP_RULE_CONF_WRITE_GAP_EN defined, test 1 stimulus -> wren alternates 1/0, 19 writes over cycles 1..37,
//     o_done in cycle 38.

Source files
------------

// File: rtl/dep_rule_conf_writer.sv
// dep_rule_conf_writer: serialises one rule record into the deparser rule-config write sequence, commit write last.
// Optional macro DEP_RULE_CONF_WRITE_GAP_EN inserts one idle cycle after every write for slow receivers.
module dep_rule_conf_writer #(
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FILED_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 5,
    parameter int HEAD_SHIFT_WIDTH  = 8,
    parameter int META_SHIFT_WIDTH  = 8,
    parameter int RULE_ID_WIDTH     = 6
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_req_valid,
    output logic                                          o_req_ready,
    input  logic [RULE_ID_WIDTH-1:0]                      i_req_ruleId,
    input  logic                                          i_req_ruleValid,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_req_typeData,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_req_typeMask,
    input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         i_req_typeOffset,
    input  logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_req_keyOffset,
    input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]     i_req_keyReplaceOffset,
    input  logic [HEAD_SHIFT_WIDTH-1:0]                   i_req_headShift,
    input  logic [META_SHIFT_WIDTH-1:0]                   i_req_metaShift,
    output logic                                          o_rule_wren,
    output logic [31:0]                                   o_rule_addr,
    output logic [31:0]                                   o_rule_wdata,
    output logic                                          o_done
);
    if (TYPE_NUM < 1 || TYPE_NUM > 16 || TYPE_WIDTH < 1 || TYPE_WIDTH > 16 ||
        TYPE_OFFSET_WIDTH < 1 || TYPE_OFFSET_WIDTH > 32 || KEY_FILED_NUM < 1 || KEY_FILED_NUM > 64 ||
        KEY_OFFSET_WIDTH < 1 || KEY_OFFSET_WIDTH > 8 || RULE_ID_WIDTH < 1 || RULE_ID_WIDTH > 6 ||
        HEAD_SHIFT_WIDTH < 1 || HEAD_SHIFT_WIDTH > 32 || META_SHIFT_WIDTH < 1 || META_SHIFT_WIDTH > 32) begin : g_bad_width
        $error("dep_rule_conf_writer: parameter width bound violated");
    end

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_TOFF, S_KEY, S_HEAD, S_META, S_COMMIT} state_t;
    state_t state, state_n;
    logic [5:0] idx;
    logic busy, step, last;

    logic [RULE_ID_WIDTH-1:0]                      rule_id_q;
    logic                                          rule_valid_q;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]                type_data_q, type_mask_q;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         type_off_q;
    logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] key_off_q;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]     key_repl_q;
    logic [HEAD_SHIFT_WIDTH-1:0]                   head_q;
    logic [META_SHIFT_WIDTH-1:0]                   meta_q;

    assign busy        = state != S_IDLE;
    assign o_req_ready = !busy;

`ifdef DEP_RULE_CONF_WRITE_GAP_EN
    // gap marks the idle cycle after a write; the commit write needs none since done follows it
    logic gap;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) gap <= 1'b0;
        else          gap <= busy && !gap && state != S_COMMIT;
    end
    assign step        = gap || state == S_COMMIT;
    assign o_rule_wren = busy && !gap;
`else
    assign step        = 1'b1;
    assign o_rule_wren = busy;
`endif

    assign last = (state == S_TYPE || state == S_TOFF) ? idx == 6'(TYPE_NUM - 1) :
                  state == S_KEY                      ? idx == 6'(KEY_FILED_NUM - 1) : 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == S_IDLE)
            state_n = i_req_valid ? S_TYPE : S_IDLE;
        else if (step && last)
            state_n = state == S_COMMIT ? S_IDLE : state_t'(state + 3'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx          <= '0;
            o_done       <= 1'b0;
            rule_id_q    <= '0;
            rule_valid_q <= 1'b0;
            type_data_q  <= '0;
            type_mask_q  <= '0;
            type_off_q   <= '0;
            key_off_q    <= '0;
            key_repl_q   <= '0;
            head_q       <= '0;
            meta_q       <= '0;
        end else begin
            idx    <= state_n != state ? '0 : idx + 6'(busy && step);
            o_done <= state == S_COMMIT;
            if (i_req_valid && o_req_ready) begin
                rule_id_q    <= i_req_ruleId;
                rule_valid_q <= i_req_ruleValid;
                type_data_q  <= i_req_typeData;
                type_mask_q  <= i_req_typeMask;
                type_off_q   <= i_req_typeOffset;
                key_off_q    <= i_req_keyOffset;
                key_repl_q   <= i_req_keyReplaceOffset;
                head_q       <= i_req_headShift;
                meta_q       <= i_req_metaShift;
            end
        end
    end

    logic [TYPE_WIDTH-1:0]        td, tm;
    logic [TYPE_OFFSET_WIDTH-1:0] toff;
    logic                         kv;
    logic [KEY_OFFSET_WIDTH-1:0]  ko, kr;
    logic [2:0]                   code;

    always_comb begin
        td   = '0;
        tm   = '0;
        toff = '0;
        kv   = 1'b0;
        ko   = '0;
        kr   = '0;
        for (int i = 0; i < TYPE_NUM; i++)
            if (idx == 6'(i)) begin
                td   = type_data_q[i*TYPE_WIDTH +: TYPE_WIDTH];
                tm   = type_mask_q[i*TYPE_WIDTH +: TYPE_WIDTH];
                toff = type_off_q[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH];
            end
        for (int i = 0; i < KEY_FILED_NUM; i++)
            if (idx == 6'(i)) begin
                kv = key_off_q[i*(KEY_OFFSET_WIDTH+1) + KEY_OFFSET_WIDTH];
                ko = key_off_q[i*(KEY_OFFSET_WIDTH+1) +: KEY_OFFSET_WIDTH];
                kr = key_repl_q[i*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH];
            end
    end

    assign code = state == S_TYPE ? 3'd1 : state == S_TOFF ? 3'd2 : state == S_KEY ? 3'd3 :
                  state == S_HEAD ? 3'd4 : state == S_META ? 3'd5 : 3'd0;

    // addr/wdata decode straight from registered state, so they hold through gap cycles
    assign o_rule_addr  = !busy              ? '0 :
                          state == S_COMMIT  ? 32'(rule_id_q) : {21'd0, code, 2'd0, idx};
    assign o_rule_wdata = state == S_TYPE   ? {16'(td), 16'(tm)} :
                          state == S_TOFF   ? 32'(toff) :
                          state == S_KEY    ? {15'd0, kv, 8'(kr), 8'(ko)} :
                          state == S_HEAD   ? 32'(head_q) :
                          state == S_META   ? 32'(meta_q) :
                          state == S_COMMIT ? 32'(rule_valid_q) : '0;
endmodule
